// File: rtl/freq_gen_pkg.sv
// Shared constants and helpers for the freq_gen clock divider / impulse generator.
package freq_gen_pkg;

  localparam int unsigned DEF_DIV = 6;
  localparam int unsigned DEF_IMP = 5;
  localparam int unsigned MIN_DIV = 2;
  localparam int unsigned MIN_IMP = 1;

  // Count value at which clk_div goes high; odd ratios get the extra high cycle.
  function automatic int unsigned clk_div_threshold(input int unsigned ratio);
    return ratio >> 1;
  endfunction

endpackage

// File: rtl/freq_gen_cnt.sv
// One wrapping channel counter with active/shadow period registers and a pending flag.
// Optional phase-align input under FREQ_GEN_SYNC_EN.
module freq_gen_cnt
  import freq_gen_pkg::*;
#(
  parameter int          W   = 8,
  parameter int unsigned DEF = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
`ifdef FREQ_GEN_SYNC_EN
  input  logic         sync,
`endif
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic [W-1:0] act,
  output logic         pend
);

  logic [W-1:0] shadow;
  logic         at_end;
  logic         apply;

  assign at_end = (cnt == act - W'(1));

`ifdef FREQ_GEN_SYNC_EN
  assign apply = sync || (en && at_end);
`else
  assign apply = en && at_end;
`endif

  // A load only happens while pend is clear, so it never collides with an apply.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      act    <= W'(DEF);
      shadow <= W'(DEF);
      pend   <= 1'b0;
    end else begin
      if (apply) begin
        cnt <= '0;
        if (pend) begin
          act  <= shadow;
          pend <= 1'b0;
        end
      end else if (en) begin
        cnt <= cnt + W'(1);
      end
      if (load) begin
        shadow <= load_val;
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/freq_gen.sv
// Runtime-programmable clock divider and periodic impulse generator.
// Optional FREQ_GEN_SYNC_EN adds a sync input that phase-aligns both channels.
module freq_gen #(
  parameter int          DIV_W   = 8,
  parameter int          IMP_W   = 8,
  parameter int unsigned DEF_DIV = freq_gen_pkg::DEF_DIV,
  parameter int unsigned DEF_IMP = freq_gen_pkg::DEF_IMP
) (
  input  logic             clk,
  input  logic             reset,
`ifdef FREQ_GEN_SYNC_EN
  input  logic             sync,
`endif
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [IMP_W-1:0] cfg_imp,
  output logic             cfg_err,
  output logic             clk_div,
  output logic             imp
);

  import freq_gen_pkg::*;

  logic [DIV_W-1:0] dcnt;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] div_thr;
  logic [IMP_W-1:0] icnt;
  logic [IMP_W-1:0] imp_act;
  logic             pend_div;
  logic             pend_imp;
  logic             cfg_fire;
  logic             cfg_bad;
  logic             cfg_load;

  assign cfg_ready = !pend_div && !pend_imp;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign cfg_bad   = (cfg_div < DIV_W'(MIN_DIV)) || (cfg_imp < IMP_W'(MIN_IMP));
  assign cfg_load  = cfg_fire && !cfg_bad;

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_fire && cfg_bad;
    end
  end

  freq_gen_cnt #(
    .W   (DIV_W),
    .DEF (DEF_DIV)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
`ifdef FREQ_GEN_SYNC_EN
    .sync     (sync),
`endif
    .load     (cfg_load),
    .load_val (cfg_div),
    .cnt      (dcnt),
    .act      (div_act),
    .pend     (pend_div)
  );

  freq_gen_cnt #(
    .W   (IMP_W),
    .DEF (DEF_IMP)
  ) u_imp (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
`ifdef FREQ_GEN_SYNC_EN
    .sync     (sync),
`endif
    .load     (cfg_load),
    .load_val (cfg_imp),
    .cnt      (icnt),
    .act      (imp_act),
    .pend     (pend_imp)
  );

  // Outputs decode registered counter state only.
  assign div_thr = DIV_W'(clk_div_threshold(32'(div_act)));
  assign clk_div = (dcnt >= div_thr);
  assign imp     = (icnt == imp_act - IMP_W'(1));

endmodule

// File: doc/freq_gen.md
# freq_gen

Runtime-programmable clock divider and periodic impulse generator: the parametrised successor of the fixed divide/impulse block. It has two independent counters. The divide ratio and the impulse period are loaded at run time through a valid/ready config port and take effect only at period boundaries. Counting can be paused, and bad configs are rejected with an error strobe. It sits in the clock/timing utilities, feeding slow strobes and divided clock-enables to downstream logic in the same `clk` domain.

## Interface
- `DIV_W`, 8: width of the divide counter and `cfg_div`.
- `IMP_W`, 8: width of the impulse counter and `cfg_imp`.
- `DEF_DIV`, 6: divide ratio after reset; must be 2..2^DIV_W-1.
- `DEF_IMP`, 5: impulse period after reset; must be 1..2^IMP_W-1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  count enable; low freezes both counters and both outputs.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config slot free.
- `cfg_div`  in  DIV_W  requested divide ratio.
- `cfg_imp`  in  IMP_W  requested impulse period.
- `cfg_err`  out  1  one-cycle strobe when a config is rejected.
- `clk_div`  out  1  divided clock (clock-enable quality, not a clock net).
- `imp`  out  1  one-cycle impulse every impulse period.

## Operation
- Divide channel:
  - `dcnt` counts 0..`div_act`-1 and then wraps to 0.
  - `clk_div` = (`dcnt` >= `div_act`/2), using integer division. The output is low for floor(div/2) cycles and high for ceil(div/2) cycles; for odd ratios the extra cycle is high.
- Impulse channel:
  - `icnt` counts 0..`imp_act`-1 and then wraps to 0.
  - `imp` = (`icnt` == `imp_act`-1). With `imp_act`=1, `imp` is constantly high.
- Both outputs are decoded from registered state only. There is no combinational path from any input to `clk_div` or `imp`.
- Config handshake:
  - A transfer occurs when `cfg_valid` && `cfg_ready`.
  - Rejection: a config with `cfg_div` < 2 or `cfg_imp` == 0 is rejected. `cfg_err`=1 on the next cycle, nothing is stored, and `cfg_ready` stays high.
  - Acceptance: a valid config is stored into the shadow registers, and `pend_div` and `pend_imp` are both set. `cfg_ready` = !`pend_div` && !`pend_imp`.
- Apply:
  - When `en`=1 and `dcnt`==`div_act`-1, `dcnt`←0; if `pend_div` is set, `div_act`←shadow and `pend_div` clears.
  - The impulse channel applies `imp_act` and clears `pend_imp` the same way, independently.
  - A transfer in the same cycle as a wrap is not applied at that wrap; it is applied at the following wrap.
- `en`=0: counters, active values, pending flags and outputs all hold. The config port still accepts and rejects configs.
- Priority: `reset` > sync (if compiled in) > `en` counting.

## Timing
- Reset values:
  - `dcnt`=0, `icnt`=0, `div_act`=`DEF_DIV`, `imp_act`=`DEF_IMP`.
  - Pending flags cleared, `cfg_ready`=1, `cfg_err`=0, `clk_div`=0.
  - `imp`=1 only if `DEF_IMP`==1, otherwise 0.
- Reset mid-operation discards any pending config. Defaults are restored on the cycle after `reset` is sampled high.
- First `imp` after reset release with `en`=1 appears `imp_act`-1 cycles after the first counting edge.
- A new ratio takes effect starting with `dcnt`=0 immediately after the wrap; there is never a partial period.
- `cfg_err` latency: 1 cycle after the rejected transfer.
- `cfg_ready` falls 1 cycle after acceptance. It rises the cycle after the later of the two channel wraps.
- Width rules:
  - All compares are unsigned at the channel width.
  - `div_act`/2 is a right shift.
  - No overflow is possible because counters never exceed `act`-1.

## Configuration
- `FREQ_GEN_SYNC_EN` defined:
  - Adds input port `sync` (1 bit).
  - `sync`=1, regardless of `en`, forces `dcnt`=`icnt`=0 on the next cycle.
  - Any pending values are applied at that point, counting as a wrap for both channels.
  - Used to phase-align several instances.
- Undefined: no `sync` port and no phase-alignment logic; behaviour is otherwise identical.

## Structure
- Package `freq_gen_pkg` holds the default constants (`DEF_DIV`, `DEF_IMP`), the minimum legal ratio (2) and period (1), and a function computing the `clk_div` threshold.
- Sub-module `freq_gen_cnt` (params `W`, `DEF`) is instantiated twice, once per channel. It contains the counter, active register, shadow register, pending flag, wrap/apply logic and optional sync.
- The top level holds the handshake, validation, `cfg_err` and output decode.

## Test plan
- Reset, `en`=1, defaults -> `clk_div` repeats 3 low / 3 high; `imp` high on cycle 4, then every 5 cycles.
- Config `cfg_div`=5, `cfg_imp`=3 accepted mid-period -> `cfg_ready` low until both wraps. After the divide wrap, `clk_div` repeats 2 low / 3 high. After the impulse wrap, `imp` fires every 3 cycles.
- Config `cfg_div`=1 (and separately `cfg_imp`=0) -> `cfg_err`=1 for exactly one cycle, `cfg_ready` stays 1, output patterns unchanged.
- `en`=0 for 7 cycles with a pending config -> outputs and counters frozen, `cfg_ready` stays 0. On resume, the config applies at the first wrap.
- `reset` asserted with `dcnt`=4 and a pending config -> next cycle `dcnt`=0, `clk_div`=0, `cfg_ready`=1. The default 6/5 pattern resumes.
- With `FREQ_GEN_SYNC_EN`, `sync` pulsed at `dcnt`=3 with a pending config -> next cycle both counters are 0 and the new values are active.
